// File: rtl/tx_link_scheduler.sv
// Round-robin scheduler sharing one parallel-load serial transmitter between
// NUM_REQ requesters: grant, load, start, supervise, then ACK or ERR the owner.
module tx_link_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int BUSY_WAIT     = 8,
  parameter int FRAME_TIMEOUT = 4096
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [NUM_REQ-1:0]      REQ,
  input  logic [32*NUM_REQ-1:0]   REQ_DATA,
  output logic [NUM_REQ-1:0]      GRANT,
  output logic [NUM_REQ-1:0]      ACK,
  output logic [NUM_REQ-1:0]      ERR,
  output logic [31:0]             TX_DIN,
  output logic                    TX_PARALLEL_LOAD,
  output logic                    TX_START,
  input  logic                    TX_BUSY,
  input  logic                    TX_DONE,
  output logic                    SCHED_BUSY
);

  localparam int LW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int MAX_WAIT = (BUSY_WAIT > FRAME_TIMEOUT) ? BUSY_WAIT : FRAME_TIMEOUT;
  localparam int CW       = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    FINISH
  } state_t;

  state_t               state, state_d;
  logic [LW-1:0]        last, last_d;
  logic [NUM_REQ-1:0]   grant, grant_d;
  logic [31:0]          din, din_d;
  logic [CW-1:0]        cnt, cnt_d, cnt_inc;
  logic                 err, err_d;

  logic                 found;
  logic [LW-1:0]        pick;
  logic [LW-1:0]        pos;

  // Scan starts just after the last winner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    pos   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      pos = LW'((int'(last) + k) % NUM_REQ);
      if (!found && REQ[pos]) begin
        found = 1'b1;
        pick  = pos;
      end
    end
  end

  // Saturating so a long wait can never wrap back under the abort threshold.
  assign cnt_inc = (cnt == {CW{1'b1}}) ? cnt : cnt + CW'(1);

  always_comb begin
    state_d = state;
    last_d  = last;
    grant_d = grant;
    din_d   = din;
    cnt_d   = cnt;
    err_d   = err;
    case (state)
      IDLE: begin
        if (found) begin
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          din_d         = REQ_DATA[32*pick +: 32];
          last_d        = pick;
          cnt_d         = '0;
          err_d         = 1'b0;
          state_d       = LOAD;
        end
      end
      LOAD: begin
        state_d = START;
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (TX_BUSY) begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= CW'(BUSY_WAIT)) begin
            err_d   = 1'b1;
            state_d = FINISH;
          end
        end
      end
      WAIT_DONE: begin
        // A done pulse or busy falling are each taken as frame end.
        if (TX_DONE || !TX_BUSY) begin
          err_d   = 1'b0;
          state_d = FINISH;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= CW'(FRAME_TIMEOUT)) begin
            err_d   = 1'b1;
            state_d = FINISH;
          end
        end
      end
      FINISH: begin
        grant_d = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      last  <= LW'(NUM_REQ - 1);
      grant <= '0;
      din   <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_d;
      last  <= last_d;
      grant <= grant_d;
      din   <= din_d;
      cnt   <= cnt_d;
      err   <= err_d;
    end
  end

  // Outputs decode registered state only, so reset clears them immediately.
  assign GRANT            = grant;
  assign TX_DIN           = din;
  assign TX_PARALLEL_LOAD = (state == LOAD);
  assign TX_START         = (state == START);
  assign ACK              = (state == FINISH && !err) ? grant : '0;
  assign ERR              = (state == FINISH &&  err) ? grant : '0;
  assign SCHED_BUSY       = (state != IDLE);

endmodule

// File: tb/tb_tx_link_scheduler.sv
// Directed bench for tx_link_scheduler: normal frames, rotation, both
// timeouts, mid-frame request changes and reset in the middle of a frame.
module tb_tx_link_scheduler;

  localparam int NUM_REQ       = 4;
  localparam int BUSY_WAIT     = 8;
  localparam int FRAME_TIMEOUT = 64;

  logic                  CLK = 1'b0;
  logic                  RESET;
  logic [NUM_REQ-1:0]    REQ;
  logic [32*NUM_REQ-1:0] REQ_DATA;
  logic [NUM_REQ-1:0]    GRANT;
  logic [NUM_REQ-1:0]    ACK;
  logic [NUM_REQ-1:0]    ERR;
  logic [31:0]           TX_DIN;
  logic                  TX_PARALLEL_LOAD;
  logic                  TX_START;
  logic                  TX_BUSY;
  logic                  TX_DONE;
  logic                  SCHED_BUSY;

  int errors = 0;
  int checks = 0;
  logic [31:0] words [NUM_REQ];

  tx_link_scheduler #(
    .NUM_REQ(NUM_REQ),
    .BUSY_WAIT(BUSY_WAIT),
    .FRAME_TIMEOUT(FRAME_TIMEOUT)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .REQ(REQ),
    .REQ_DATA(REQ_DATA),
    .GRANT(GRANT),
    .ACK(ACK),
    .ERR(ERR),
    .TX_DIN(TX_DIN),
    .TX_PARALLEL_LOAD(TX_PARALLEL_LOAD),
    .TX_START(TX_START),
    .TX_BUSY(TX_BUSY),
    .TX_DONE(TX_DONE),
    .SCHED_BUSY(SCHED_BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  // Called in an IDLE cycle with the owner's request visible; ends back in IDLE.
  task automatic run_frame(input int owner, input int busy_len, input bit release_req);
    tick();
    check_output("load_grant", 32'(GRANT), 32'(1) << owner);
    check_output("load_strobe", 32'(TX_PARALLEL_LOAD), 32'd1);
    check_output("load_no_start", 32'(TX_START), 32'd0);
    check_output("load_din", TX_DIN, words[owner]);
    tick();
    check_output("start_strobe", 32'(TX_START), 32'd1);
    check_output("start_no_load", 32'(TX_PARALLEL_LOAD), 32'd0);
    tick();
    TX_BUSY = 1'b1;
    repeat (busy_len) tick();
    check_output("ack_quiet", 32'(ACK), 32'd0);
    TX_BUSY = 1'b0;
    tick();
    check_output("ack_pulse", 32'(ACK), 32'(1) << owner);
    check_output("ack_no_err", 32'(ERR), 32'd0);
    if (release_req) REQ[owner] = 1'b0;
    tick();
    check_output("ack_one_cycle", 32'(ACK), 32'd0);
    check_output("grant_clear", 32'(GRANT), 32'd0);
    check_output("idle_not_busy", 32'(SCHED_BUSY), 32'd0);
  endtask

  initial begin
    words[0] = 32'hA5A5_0F0F;
    words[1] = 32'h1111_2222;
    words[2] = 32'h3333_4444;
    words[3] = 32'h5555_6666;
    REQ_DATA = {words[3], words[2], words[1], words[0]};
    RESET    = 1'b1;
    REQ      = '0;
    TX_BUSY  = 1'b0;
    TX_DONE  = 1'b0;

    repeat (2) @(posedge CLK);
    #1;
    check_output("rst_grant", 32'(GRANT), 32'd0);
    check_output("rst_din", TX_DIN, 32'd0);
    check_output("rst_sched_busy", 32'(SCHED_BUSY), 32'd0);
    check_output("rst_strobes", 32'({TX_PARALLEL_LOAD, TX_START}), 32'd0);
    check_output("rst_ack_err", 32'({ACK, ERR}), 32'd0);
    RESET = 1'b0;

    // Single request from requester 0
    REQ = 4'b0001;
    run_frame(0, 40, 1'b1);

    // All requesting: rotation continues after requester 0
    REQ = 4'b1111;
    run_frame(1, 3, 1'b0);
    run_frame(2, 3, 1'b0);
    run_frame(3, 3, 1'b0);
    run_frame(0, 3, 1'b0);

    // Busy timeout on requester 1: transmitter never goes busy
    tick();
    check_output("bto_grant", 32'(GRANT), 32'b0010);
    tick();
    tick();
    repeat (BUSY_WAIT - 1) tick();
    check_output("bto_err_early", 32'(ERR), 32'd0);
    tick();
    check_output("bto_err", 32'(ERR), 32'b0010);
    check_output("bto_no_ack", 32'(ACK), 32'd0);
    tick();
    check_output("bto_err_one_cycle", 32'(ERR), 32'd0);
    check_output("bto_idle", 32'(SCHED_BUSY), 32'd0);

    // Next requester proceeds; busy stuck high forces the frame timeout
    tick();
    check_output("fto_grant", 32'(GRANT), 32'b0100);
    check_output("fto_din", TX_DIN, words[2]);
    tick();
    tick();
    TX_BUSY = 1'b1;
    tick();
    repeat (FRAME_TIMEOUT - 1) tick();
    check_output("fto_err_early", 32'(ERR), 32'd0);
    check_output("fto_busy_held", 32'(SCHED_BUSY), 32'd1);
    tick();
    check_output("fto_err", 32'(ERR), 32'b0100);
    check_output("fto_no_ack", 32'(ACK), 32'd0);
    check_output("fto_busy_at_pulse", 32'(SCHED_BUSY), 32'd1);
    TX_BUSY = 1'b0;
    REQ = 4'b0001;
    tick();
    check_output("fto_busy_fall", 32'(SCHED_BUSY), 32'd0);
    check_output("fto_err_one_cycle", 32'(ERR), 32'd0);

    // Requester 0 drops mid-frame while requester 2 arrives
    tick();
    check_output("mid_grant0", 32'(GRANT), 32'b0001);
    tick();
    tick();
    TX_BUSY = 1'b1;
    tick();
    REQ = 4'b0100;
    repeat (3) tick();
    check_output("mid_grant_frozen", 32'(GRANT), 32'b0001);
    check_output("mid_din_frozen", TX_DIN, words[0]);
    TX_DONE = 1'b1;
    tick();
    check_output("mid_ack", 32'(ACK), 32'b0001);
    TX_DONE = 1'b0;
    TX_BUSY = 1'b0;
    tick();
    tick();
    check_output("mid_next_grant", 32'(GRANT), 32'b0100);
    check_output("mid_next_din", TX_DIN, words[2]);

    // Reset in the middle of requester 2's frame
    tick();
    tick();
    TX_BUSY = 1'b1;
    tick();
    tick();
    REQ = 4'b1111;
    #2;
    RESET = 1'b1;
    #1;
    check_output("mrst_grant", 32'(GRANT), 32'd0);
    check_output("mrst_sched_busy", 32'(SCHED_BUSY), 32'd0);
    check_output("mrst_din", TX_DIN, 32'd0);
    check_output("mrst_ack_err", 32'({ACK, ERR}), 32'd0);
    TX_BUSY = 1'b0;
    @(posedge CLK);
    #1;
    check_output("mrst_held_ack_err", 32'({ACK, ERR}), 32'd0);
    check_output("mrst_held_grant", 32'(GRANT), 32'd0);
    RESET = 1'b0;
    tick();
    check_output("mrst_first_grant", 32'(GRANT), 32'b0001);
    check_output("mrst_first_din", TX_DIN, words[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tx_link_scheduler.md
Name: tx_link_scheduler

Overview:
- Round-robin scheduler that shares the single 32-bit parallel-load serial transmitter between NUM_REQ requesters.
- Per grant: selects a requester, drives the transmitter's parallel-load strobe, then its start strobe, and supervises the frame until the transmitter reports idle.
- Returns a per-requester completion or error pulse to the winning requester.
- Sits between the packet sources and the transmitter; all transmitter handshake inputs are synchronous to CLK.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BUSY_WAIT, 8, max CLK cycles from start strobe to TX_BUSY high before abort.
- FRAME_TIMEOUT, 4096, max CLK cycles in WAIT_DONE before abort.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- REQ  input  NUM_REQ  level request per requester; held until ACK or ERR for that requester.
- REQ_DATA  input  32*NUM_REQ  frame word per requester; requester i uses bits [32i+31:32i]; stable while REQ[i] is high.
- GRANT  output  NUM_REQ  one-hot owner of the transmitter; all zero when idle.
- ACK  output  NUM_REQ  one-cycle pulse to the owner on successful frame end.
- ERR  output  NUM_REQ  one-cycle pulse to the owner on timeout abort.
- TX_DIN  output  32  word driven to the transmitter parallel input.
- TX_PARALLEL_LOAD  output  1  load strobe to transmitter.
- TX_START  output  1  start strobe to transmitter.
- TX_BUSY  input  1  transmitter busy flag.
- TX_DONE  input  1  transmitter done flag.
- SCHED_BUSY  output  1  high whenever state != IDLE.

Behaviour:
- Reset (asynchronous): all outputs 0, TX_DIN 0, state IDLE, round-robin pointer last = NUM_REQ-1 (so requester 0 wins first), counters 0.
- States: IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, FINISH.
- IDLE:
  - If any REQ is high, pick the first set bit scanning last+1, last+2, … with wrap-around modulo NUM_REQ.
  - Register GRANT one-hot and TX_DIN = that requester's word; update last to the winner; go to LOAD.
  - If no request, stay in IDLE.
- LOAD:
  - TX_PARALLEL_LOAD = 1 for exactly one cycle; TX_START = 0.
  - Go to START.
- START:
  - TX_START = 1 for exactly one cycle; TX_PARALLEL_LOAD = 0.
  - Clear the counter; go to WAIT_BUSY.
  - TX_PARALLEL_LOAD and TX_START are never high in the same cycle.
- WAIT_BUSY:
  - If TX_BUSY = 1, clear the counter and go to WAIT_DONE.
  - Else increment the counter; if counter reaches BUSY_WAIT, abort with error.
- WAIT_DONE:
  - Completion when TX_DONE = 1 or TX_BUSY = 0 (either sufficient).
  - On completion go to FINISH with ok.
  - Else increment the counter; if counter reaches FRAME_TIMEOUT, abort with error.
- FINISH (one cycle):
  - Pulse ACK[owner] (ok) or ERR[owner] (error); exactly one of them, exactly one cycle.
  - Clear GRANT; go to IDLE.
  - Minimum gap between frames is therefore one IDLE cycle.
- Latency:
  - REQ rise in IDLE to TX_PARALLEL_LOAD: 2 cycles (IDLE registers the grant, LOAD asserts the strobe).
  - TX_START follows 1 cycle after TX_PARALLEL_LOAD.
- Arbitration rules:
  - GRANT and TX_DIN are frozen from IDLE exit until FINISH completes.
  - Requests arriving mid-frame wait.
  - A requester dropping REQ mid-frame does not abort the frame; it still receives ACK/ERR.
- Fairness: with all requesters asserting continuously, grants rotate 0,1,2,3,0,…
- Counter width: enough bits for max(BUSY_WAIT, FRAME_TIMEOUT); saturates, never wraps.
- TX_DONE or TX_BUSY activity while in IDLE, LOAD or START is ignored.
- RESET mid-frame: immediate return to reset values.
  - No ACK/ERR is emitted for the interrupted frame.
  - The round-robin pointer returns to NUM_REQ-1.

Test Plan:
- Single request: REQ=0001, REQ_DATA[31:0]=0xA5A5_0F0F; model transmitter raises TX_BUSY 1 cycle after TX_START and drops it 40 cycles later -> GRANT=0001; TX_PARALLEL_LOAD at cycle 2 with TX_DIN=0xA5A5_0F0F; TX_START at cycle 3; ACK=0001 one-cycle pulse; GRANT returns to 0.
- Round-robin: REQ=1111 held, each requester's word distinct -> grant order 0,1,2,3,0; each TX_DIN matches its grantee; one ACK per frame; loads and starts never overlap.
- Busy timeout: transmitter never raises TX_BUSY, BUSY_WAIT=8 -> ERR[owner] pulses 8 cycles after entering WAIT_BUSY; no ACK; scheduler proceeds to the next requester.
- Frame timeout: TX_BUSY stuck high, FRAME_TIMEOUT=64 -> ERR after 64 cycles in WAIT_DONE; SCHED_BUSY falls the cycle after the pulse.
- Mid-frame events: REQ[2] asserts during REQ[0]'s WAIT_DONE and REQ[0] drops -> frame 0 completes with ACK[0]; requester 2 is granted next.
- Reset mid-frame: assert RESET in WAIT_DONE -> all outputs 0 asynchronously; no ACK/ERR; after release with REQ=1111, requester 0 is granted first.
